// File: rtl/speech_fb_pkg.sv
// Shared types and constants for the speech frame ping-pong buffer.
package speech_fb_pkg;

  localparam int FB_FRAME_LEN = 160;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ANNOUNCE,
    R_SERVE,
    R_RELEASE
  } rd_state_t;

  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;
  localparam logic [15:0]        SAT_POS = 16'h7fff;
  localparam logic [15:0]        SAT_NEG = 16'h8000;

  // Clamp an 18-bit intermediate back into the signed 16-bit sample range.
  function automatic logic [15:0] sat16(input logic signed [17:0] v);
    if (v > SAT_MAX)      return SAT_POS;
    else if (v < SAT_MIN) return SAT_NEG;
    else                  return v[15:0];
  endfunction

endpackage

// File: rtl/fb_bank_ram.sv
// Two-bank sample store: one write port, one registered read port.
// The address MSB selects the bank, the low bits the sample within it.
module fb_bank_ram #(
  parameter int FRAME_LEN = 160,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [15:0]       rd_data
);

  logic [15:0] mem [2][FRAME_LEN];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[ADDR_W]][wr_addr[ADDR_W-1:0]] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr[ADDR_W]][rd_addr[ADDR_W-1:0]];
  end

endmodule

// File: rtl/speech_frame_buffer.sv
// Ping-pong speech sample buffer serving subframes byte-serially to the core.
// Optional pre-emphasis filter on the write path: define FB_PREEMPH_EN.
module speech_frame_buffer
  import speech_fb_pkg::*;
#(
  parameter int FRAME_LEN = FB_FRAME_LEN,
  parameter int ADDR_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  output logic        adc_ready,
  output logic        frame_start,
  input  logic        rd_req,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        frame_end,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   LAST_BYTE = (ADDR_W + 1)'(2 * FRAME_LEN - 1);

  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   rd_byte;
  logic              rd_bank, oldest, wr_bank, full_sel;
  logic              wr_fire, wr_last, rd_fire, rd_last, any_full;
  logic              hi_sel;
  logic [15:0]       ram_q, store_data;

  assign adc_ready = (bank_q[0] == BANK_FILLING) || (bank_q[1] == BANK_FILLING);
  assign wr_bank   = (bank_q[1] == BANK_FILLING);
  assign wr_fire   = adc_valid && adc_ready;
  assign wr_last   = wr_fire && (wr_ptr == LAST_PTR);
  assign rd_fire   = (state_q == R_SERVE) && rd_req;
  assign rd_last   = rd_fire && (rd_byte == LAST_BYTE);
  assign any_full  = (bank_q[0] == BANK_FULL) || (bank_q[1] == BANK_FULL);
  assign full_sel  = ((bank_q[0] == BANK_FULL) && (bank_q[1] == BANK_FULL)) ?
                     oldest : (bank_q[1] == BANK_FULL);
  assign rd_data   = rd_valid ? (hi_sel ? ram_q[15:8] : ram_q[7:0]) : 8'h00;

`ifdef FB_PREEMPH_EN
  logic signed [15:0] x_prev;
  logic signed [17:0] x_ext, p_ext, emph;

  assign x_ext      = {{2{adc_data[15]}}, adc_data};
  assign p_ext      = {{2{x_prev[15]}}, x_prev};
  assign emph       = x_ext - p_ext + (p_ext >>> 5);
  assign store_data = sat16(emph);

  // Only accepted samples advance the filter history.
  always_ff @(posedge clk) begin
    if (reset)        x_prev <= '0;
    else if (wr_fire) x_prev <= adc_data;
  end
`else
  assign store_data = adc_data;
`endif

  fb_bank_ram #(
    .FRAME_LEN (FRAME_LEN),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_ptr}),
    .wr_data (store_data),
    .rd_en   (rd_fire),
    .rd_addr ({rd_bank, rd_byte[ADDR_W:1]}),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= R_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:     if (any_full) state_d = R_ANNOUNCE;
      R_ANNOUNCE: state_d = R_SERVE;
      R_SERVE:    if (rd_last) state_d = R_RELEASE;
      R_RELEASE:  state_d = R_IDLE;
      default:    state_d = R_IDLE;
    endcase
  end

  // Write-side transitions are applied first so a release in the same cycle
  // sees the bank that has just become FULL and takes over filling.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    if (wr_last) begin
      bank_d[wr_bank] = BANK_FULL;
      if (bank_q[~wr_bank] == BANK_EMPTY) bank_d[~wr_bank] = BANK_FILLING;
    end
    if (state_q == R_ANNOUNCE) bank_d[rd_bank] = BANK_READING;
    if (state_q == R_RELEASE)
      bank_d[rd_bank] = (bank_d[~rd_bank] == BANK_FILLING) ? BANK_EMPTY : BANK_FILLING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]   <= BANK_FILLING;
      bank_q[1]   <= BANK_EMPTY;
      wr_ptr      <= '0;
      rd_byte     <= '0;
      rd_bank     <= 1'b0;
      oldest      <= 1'b0;
      hi_sel      <= 1'b0;
      frame_start <= 1'b0;
      rd_valid    <= 1'b0;
      frame_end   <= 1'b0;
      overrun     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      frame_start <= (state_q == R_ANNOUNCE);
      rd_valid    <= rd_fire;
      frame_end   <= rd_last;
      hi_sel      <= rd_byte[0];
      if (wr_fire) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
      // A bank completing while the other still waits is the younger one.
      if (wr_last && (bank_q[~wr_bank] != BANK_FULL)) oldest <= wr_bank;
      if (state_q == R_IDLE) rd_bank <= full_sel;
      if (rd_fire) rd_byte <= rd_last ? '0 : rd_byte + 1'b1;
      if (state_q == R_RELEASE) frame_cnt <= frame_cnt + 16'd1;
      if (adc_valid && !adc_ready) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_speech_frame_buffer.sv
// Self-checking bench for speech_frame_buffer (FRAME_LEN=4) against a
// queue-based model of accepted samples, served bytes and buffer occupancy.
module tb_speech_frame_buffer;

  localparam int FL = 4;
  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_valid = 1'b0;
  logic [15:0] adc_data = '0;
  logic        rd_req = 1'b0;
  logic        adc_ready, frame_start, rd_valid, frame_end, overrun;
  logic [7:0]  rd_data;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  speech_frame_buffer #(
    .FRAME_LEN (FL),
    .ADDR_W    (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .adc_ready   (adc_ready),
    .frame_start (frame_start),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .frame_end   (frame_end),
    .overrun     (overrun),
    .frame_cnt   (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: complete frames held (FULL or being read), partial frame, byte streams.
  int          stored_cnt = 0;
  int          served = 0;
  int          fs_count = 0;
  bit          rel_pending = 1'b0;
  bit          m_overrun = 1'b0;
  logic [15:0] m_frame_cnt = '0;
  logic [15:0] partial [$];
  logic [8:0]  exp_q [$];
  logic [8:0]  obs_q [$];
  logic [8:0]  gold [8] = '{9'h002, 9'h001, 9'h004, 9'h003, 9'h006, 9'h005, 9'h008, 9'h107};
`ifdef FB_PREEMPH_EN
  logic [15:0] m_prev = '0;
`endif

  function automatic logic [15:0] model_store(input logic [15:0] x);
`ifdef FB_PREEMPH_EN
    int xv, pv, y;
    xv = int'($signed(x));
    pv = int'($signed(m_prev));
    y  = xv - pv + (pv >>> 5);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y[15:0];
`else
    return x;
`endif
  endfunction

  task automatic model_clear();
    stored_cnt  = 0;
    served      = 0;
    rel_pending = 1'b0;
    m_overrun   = 1'b0;
    m_frame_cnt = '0;
    partial.delete();
    exp_q.delete();
    obs_q.delete();
`ifdef FB_PREEMPH_EN
    m_prev = '0;
`endif
  endtask

  // Advance one clock: update the model with the inputs seen at the edge,
  // then capture DUT outputs 1 ns later.
  task automatic tick();
    bit          ready_pre;
    logic [15:0] v;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      ready_pre = (stored_cnt < 2);
      if (adc_valid && !ready_pre) m_overrun = 1'b1;
      if (rel_pending) begin
        stored_cnt--;
        m_frame_cnt = m_frame_cnt + 16'd1;
        rel_pending = 1'b0;
      end
      if (adc_valid && ready_pre) begin
        v = model_store(adc_data);
`ifdef FB_PREEMPH_EN
        m_prev = adc_data;
`endif
        partial.push_back(v);
        if (partial.size() == FL) begin
          for (int i = 0; i < FL; i++) begin
            exp_q.push_back({1'b0, partial[i][7:0]});
            exp_q.push_back({(i == FL - 1), partial[i][15:8]});
          end
          partial.delete();
          stored_cnt++;
        end
      end
    end
    #1;
    if (rd_valid === 1'b1) begin
      obs_q.push_back({frame_end, rd_data});
      served++;
      if (served == 2 * FL) begin
        served      = 0;
        rel_pending = 1'b1;
      end
    end
    if (frame_start === 1'b1) fs_count++;
  endtask

  task automatic do_reset();
    reset = 1'b1; adc_valid = 1'b0; rd_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic feed_frame();
    for (int i = 0; i < FL; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'($urandom);
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (frame_start === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0; rd_req = 1'b1; adc_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (stored_cnt == 0 && !rel_pending) begin ok = 1'b1; break; end
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; adc_valid = 1'b0; rd_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (adc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_adc_ready got=%b exp=1", adc_ready); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got=%b exp=0", frame_start); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got=%h exp=00", rd_data); end
    checks++; if (frame_end !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_end got=%b exp=0", frame_end); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_basic_frame();
    logic [15:0] vals [4] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1; adc_data = vals[i];
      tick();
    end
    adc_valid = 1'b0;
    tick();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL basic_fs_early got=%b exp=0", frame_start); end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL basic_fs_latency got=%b exp=1", frame_start); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL basic_drain_timeout got=%0d bytes exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL basic_byte_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
`ifndef FB_PREEMPH_EN
      checks++;
      if (i < 8 && obs_q[i] !== gold[i]) begin errors++; $display("[TB] FAIL basic_gold[%0d] got=%h exp=%h", i, obs_q[i], gold[i]); end
`endif
    end
    obs_q.delete(); exp_q.delete();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL basic_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      adc_valid = 1'b1; adc_data = 16'($urandom);
      tick();
      checks++;
      if (adc_ready !== (stored_cnt < 2)) begin errors++; $display("[TB] FAIL ovr_adc_ready[%0d] got=%b exp=%b", i, adc_ready, (stored_cnt < 2)); end
      if (i == 7) begin
        checks++; if (adc_ready !== 1'b0) begin errors++; $display("[TB] FAIL ovr_ready_after_8 got=%b exp=0", adc_ready); end
      end
    end
    adc_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_flag got=%b exp=1", overrun); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovr_drain_timeout got=%0d bytes exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL ovr_byte_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL ovr_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL ovr_frame_cnt got=%0d exp=2", frame_cnt); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_idle_req();
    bit ok;
    int fs0;
    do_reset();
    fs0 = fs_count;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_valid[%0d] got=%b exp=0", i, rd_valid); end
    end
    rd_req = 1'b0;
    checks++; if (fs_count != fs0) begin errors++; $display("[TB] FAIL idle_frame_start got=%0d exp=%0d", fs_count, fs0); end
    feed_frame();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL idle_drain_timeout got=%0d bytes exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL idle_byte_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL idle_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int fs_before;
    do_reset();
    feed_frame();
    wait_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_first_fs got=0 exp=1"); end
    rd_req = 1'b1;
    fs_before = fs_count;
    for (int k = 1; k <= 11; k++) begin
      adc_valid = (k >= 6 && k <= 9);
      adc_data  = 16'($urandom);
      tick();
      checks++;
      if (adc_ready !== (stored_cnt < 2)) begin errors++; $display("[TB] FAIL b2b_adc_ready[%0d] got=%b exp=%b", k, adc_ready, (stored_cnt < 2)); end
      if (k == 9) fs_before = fs_count;
    end
    adc_valid = 1'b0;
    checks++; if (fs_count - fs_before != 1) begin errors++; $display("[TB] FAIL b2b_second_fs got=%0d exp=1", fs_count - fs_before); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_drain_timeout got=%0d bytes exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got=%b exp=0", overrun); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL b2b_byte_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL b2b_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL b2b_frame_cnt got=%0d exp=2", frame_cnt); end
  endtask

  task automatic test_reset_mid_serve();
    bit ok;
    do_reset();
    feed_frame();
    wait_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rms_fs got=0 exp=1"); end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; tick();
      rd_req = 1'b0; tick();
    end
    checks++; if (obs_q.size() != 3) begin errors++; $display("[TB] FAIL rms_partial_count got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rms_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (adc_ready !== 1'b1) begin errors++; $display("[TB] FAIL rms_adc_ready got=%b exp=1", adc_ready); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || frame_end !== 1'b0 || frame_start !== 1'b0) begin
      errors++; $display("[TB] FAIL rms_outputs got=%b/%h/%b/%b exp=0/00/0/0", rd_valid, rd_data, frame_end, frame_start);
    end
    checks++; if (frame_cnt !== 16'd0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL rms_counters got=%0d/%b exp=0/0", frame_cnt, overrun); end
    feed_frame();
    drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rms_drain_timeout got=%0d bytes exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rms_byte_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rms_new_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL rms_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      adc_valid = ($urandom_range(0, 9) < 6);
      adc_data  = 16'($urandom);
      rd_req    = ($urandom_range(0, 9) < 4);
      tick();
      checks++;
      if (adc_ready !== (stored_cnt < 2)) begin errors++; $display("[TB] FAIL rand_adc_ready[%0d] got=%b exp=%b", n, adc_ready, (stored_cnt < 2)); end
      checks++;
      if (overrun !== m_overrun) begin errors++; $display("[TB] FAIL rand_overrun[%0d] got=%b exp=%b", n, overrun, m_overrun); end
    end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rand_drain_timeout got=%0d bytes exp=%0d", obs_q.size(), exp_q.size()); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL rand_byte_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rand_byte[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    checks++; if (frame_cnt !== m_frame_cnt) begin errors++; $display("[TB] FAIL rand_frame_cnt got=%0d exp=%0d", frame_cnt, m_frame_cnt); end
  endtask

`ifdef FB_PREEMPH_EN
  task automatic test_preemph();
    logic [15:0] vin  [4] = '{16'd1000, 16'd1000, 16'h7fff, 16'h8000};
    logic [15:0] vout [4] = '{16'd1000, 16'd31, 16'd31798, 16'h8000};
    logic [15:0] got;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1; adc_data = vin[i];
      tick();
    end
    adc_valid = 1'b0;
    drain(ok);
    checks++; if (obs_q.size() != 8) begin errors++; $display("[TB] FAIL pre_byte_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < 4 && 2 * i + 1 < obs_q.size(); i++) begin
      got = {obs_q[2 * i + 1][7:0], obs_q[2 * i][7:0]};
      checks++;
      if (got !== vout[i]) begin errors++; $display("[TB] FAIL pre_sample[%0d] got=%h exp=%h", i, got, vout[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
`endif

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_overrun();
    test_idle_req();
    test_back_to_back();
    test_reset_mid_serve();
`ifdef FB_PREEMPH_EN
    test_preemph();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/speech_frame_buffer.md
# speech_frame_buffer

Ping-pong sample buffer upstream of the feature-extraction core in `test_core`. It collects signed 16-bit speech samples from the ADC side into subframes of `FRAME_LEN` samples. It announces each completed subframe with a start pulse and serves it to the core byte-serially, low byte first, over a request/data port. Overrun is flagged when the core falls more than one subframe behind.

## Interface
- `FRAME_LEN`, 160: samples per subframe.
- `ADDR_W`, 8: per-bank sample address width. Must satisfy `2**ADDR_W >= FRAME_LEN`.
- `clk`, in, 1: system clock, rising edge.
- `reset`, in, 1: reset, synchronous, active-high.
- `adc_valid`, in, 1: sample strobe.
- `adc_data`, in, 16: signed sample, two's complement.
- `adc_ready`, out, 1: buffer can accept a sample this cycle.
- `frame_start`, out, 1: one-cycle pulse when a subframe becomes readable.
- `rd_req`, in, 1: core requests the next byte.
- `rd_data`, out, 8: served byte.
- `rd_valid`, out, 1: `rd_data` is valid.
- `frame_end`, out, 1: one-cycle pulse with the last byte of a subframe.
- `overrun`, out, 1: sticky flag; a sample was dropped.
- `frame_cnt`, out, 16: subframes released since reset, wraps.

## Operation
- Two banks, A and B, each `FRAME_LEN` x 16. Each bank is EMPTY, FILLING, FULL or READING. After reset: A is FILLING, B is EMPTY.
- Write side: a sample is stored only when `adc_valid & adc_ready`. Samples go to the FILLING bank at `wr_ptr`, which increments on each store.
  - When `wr_ptr` reaches `FRAME_LEN-1` and that sample is written, the bank becomes FULL and `wr_ptr` returns to 0.
  - If the other bank is EMPTY, it becomes FILLING in the same cycle.
- `adc_ready` is 0 only when no bank is FILLING (both FULL/READING). In that case, `adc_valid=1` sets `overrun` and the sample is dropped. `overrun` clears only on reset.
- Read FSM states:
  - R_IDLE: if a FULL bank exists, move to R_ANNOUNCE. When both banks are FULL, the oldest bank goes first.
  - R_ANNOUNCE: the selected bank becomes READING; `frame_start`=1 for this cycle; move to R_SERVE.
  - R_SERVE: each `rd_req` returns one byte. Byte index `b` runs from 0 to `2*FRAME_LEN-1`; sample `b>>1`, low byte when `b[0]=0`, high byte otherwise. The last byte asserts `frame_end`; move to R_RELEASE.
  - R_RELEASE: the bank becomes EMPTY and `frame_cnt` increments. If no bank is FILLING, this bank becomes FILLING in the same cycle. Return to R_IDLE.
- `rd_req` outside R_SERVE is ignored: no `rd_valid` is produced and the read state is unchanged.
- Simultaneous events:
  - Write-bank fill and read release in the same cycle: the released bank becomes FILLING, and the newly FULL bank is picked up in R_IDLE on the next cycle.
  - Write and read on the same bank cannot occur; bank states exclude it.

## Timing
- All outputs are 0 after reset, except `adc_ready`=1.
- Reset mid-operation: both pointers, the FSM, bank states, `overrun` and `frame_cnt` clear on the next edge. Partial subframes are discarded.
- Latency:
  - Last sample written to `frame_start` pulse: 2 cycles (edge N stores the sample, N+1 is R_IDLE, N+2 is R_ANNOUNCE), provided read is idle.
  - `rd_req` at edge N gives `rd_data`/`rd_valid` during cycle N+1.
  - `rd_req` may be held high for back-to-back bytes, one byte per cycle.
  - `frame_end` is coincident with `rd_valid` of byte `2*FRAME_LEN-1`.
- Throughput: one sample per cycle on the write side.

## Configuration
- `FB_PREEMPH_EN` defined: each sample is pre-emphasised before storage as `y = x - x_prev + (x_prev >>> 5)`.
  - Internal precision is 18-bit signed; the result saturates to [-32768, 32767].
  - `x_prev` is the previous accepted sample, 0 after reset. Dropped samples do not update `x_prev`.
- `FB_PREEMPH_EN` undefined: samples are stored unmodified. The filter logic and `x_prev` are absent.

## Structure
- Package `speech_fb_pkg`: default `FRAME_LEN`, bank-state enum (EMPTY/FILLING/FULL/READING), read-FSM enum, saturation constants.
- Sub-module `fb_bank_ram`: simple dual-port synchronous RAM, 2 x `FRAME_LEN` x 16, one write port, one registered read port. The bank select is the MSB of the address. The top level holds the FSM, pointers and filter.

## Test plan
- `FRAME_LEN`=4, macro off, feed samples 0x0102, 0x0304, 0x0506, 0x0708, then hold `rd_req`=1 -> `frame_start` 2 cycles after the 4th sample. `rd_data` sequence is 02,01,04,03,06,05,08,07; `frame_end` with 07; `frame_cnt`=1.
- Stall the reader and stream 9 samples -> `adc_ready`=0 after the 8th sample; 9th sample dropped; `overrun`=1. First frame served is samples 1–4.
- Pulse `rd_req` in R_IDLE -> no `rd_valid`; read state unchanged.
- Release a frame in the same cycle the other bank fills -> no dropped sample; second `frame_start` follows within 2 cycles.
- Assert `reset` mid-serve after 3 bytes -> all outputs 0, `adc_ready`=1 on the next cycle; a new frame is served from byte 0.
- Macro on, inputs 1000, 1000 -> stored values 1000 and 31 (1000 - 1000 + 31). Inputs -32768 after 32767 -> stored value saturates to -32768.
